// File: rtl/adpcm_main_mul_pipe.sv
// Pipelined multiplier for the ADPCM datapath: full product, optional round-half-up, arithmetic right shift,
// fit to dout_WIDTH, then a ce-gated NUM_STAGE register chain. Define ADPCM_MUL_SAT_EN to saturate (with ovf) instead of wrapping.
module adpcm_main_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SHIFT      = 15,
  parameter int ROUND      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  vld_in,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  vld_out,
  output logic                  ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  // Working width holds the exact product, the rounding carry and both saturation limits.
  localparam int XW = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 2;
  localparam logic signed [XW-1:0] ONE = XW'(1);
  localparam logic signed [XW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  if (NUM_STAGE < 0 || NUM_STAGE > 8) begin : g_bad_stage
    $error("adpcm_main_mul_pipe ID=%0d: NUM_STAGE=%0d outside 0..8", ID, NUM_STAGE);
  end
  if (SHIFT < 0 || SHIFT > PW - 1) begin : g_bad_shift
    $error("adpcm_main_mul_pipe ID=%0d: SHIFT=%0d outside 0..%0d", ID, SHIFT, PW - 1);
  end

  logic signed [XW-1:0]  w_a;
  logic signed [XW-1:0]  w_b;
  logic signed [XW-1:0]  w_p;
  logic signed [XW-1:0]  w_r;
  logic [dout_WIDTH-1:0] w_dout;
  logic                  w_ovf;

  // Unsigned operands are zero-extended, so a single signed multiply covers every signedness mix.
  assign w_a = {{(XW-din0_WIDTH){(SIGNED0 != 0) && din0[din0_WIDTH-1]}}, din0};
  assign w_b = {{(XW-din1_WIDTH){(SIGNED1 != 0) && din1[din1_WIDTH-1]}}, din1};
  assign w_p = w_a * w_b;
  assign w_r = (w_p + RND) >>> SHIFT;

`ifdef ADPCM_MUL_SAT_EN
  localparam bit SGN = (SIGNED0 != 0) || (SIGNED1 != 0);
  localparam logic signed [XW-1:0] MAXV =
    SGN ? (ONE <<< (dout_WIDTH - 1)) - ONE : (ONE <<< dout_WIDTH) - ONE;
  localparam logic signed [XW-1:0] MINV = SGN ? -(ONE <<< (dout_WIDTH - 1)) : '0;

  always_comb begin
    w_dout = w_r[dout_WIDTH-1:0];
    w_ovf  = 1'b0;
    if (w_r > MAXV) begin
      w_dout = MAXV[dout_WIDTH-1:0];
      w_ovf  = 1'b1;
    end else if (w_r < MINV) begin
      w_dout = MINV[dout_WIDTH-1:0];
      w_ovf  = 1'b1;
    end
  end
`else
  assign w_dout = w_r[dout_WIDTH-1:0];
  assign w_ovf  = 1'b0;
`endif

  // vld_out qualifies dout/ovf; there is no backpressure, a result is simply present for one ce-high cycle.
  if (NUM_STAGE == 0) begin : g_comb
    assign dout    = w_dout;
    assign vld_out = vld_in;
    assign ovf     = w_ovf;
  end else begin : g_pipe
    logic                  r_vld  [NUM_STAGE];
    logic [dout_WIDTH-1:0] r_dout [NUM_STAGE];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < NUM_STAGE; i++) begin
          r_vld[i]  <= 1'b0;
          r_dout[i] <= '0;
        end
      end else if (ce) begin
        r_vld[0]  <= vld_in;
        r_dout[0] <= w_dout;
        for (int i = 1; i < NUM_STAGE; i++) begin
          r_vld[i]  <= r_vld[i-1];
          r_dout[i] <= r_dout[i-1];
        end
      end
    end

    assign dout    = r_dout[NUM_STAGE-1];
    assign vld_out = r_vld[NUM_STAGE-1];

`ifdef ADPCM_MUL_SAT_EN
    logic r_ovf [NUM_STAGE];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < NUM_STAGE; i++) r_ovf[i] <= 1'b0;
      end else if (ce) begin
        r_ovf[0] <= w_ovf;
        for (int i = 1; i < NUM_STAGE; i++) r_ovf[i] <= r_ovf[i-1];
      end
    end

    assign ovf = r_ovf[NUM_STAGE-1];
`else
    assign ovf = 1'b0;
`endif
  end

endmodule

// File: tb/tb_adpcm_main_mul_pipe.sv
// Directed bench for adpcm_main_mul_pipe: five instances (latency, rounding, saturation, reset, combinational)
// share one operand bus; each step checks hand-computed results with immediate assertions.
module tb_adpcm_main_mul_pipe;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        vld_in;
  logic [14:0] din0;
  logic [31:0] din1;

  logic [46:0] d_lat;
  logic        v_lat, o_lat;
  logic [31:0] d_rnd;
  logic        v_rnd, o_rnd;
  logic [15:0] d_sat;
  logic        v_sat, o_sat;
  logic [31:0] d_rst;
  logic        v_rst, o_rst;
  logic [31:0] d_cmb;
  logic        v_cmb, o_cmb;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [46:0] E_M3000 = -47'sd3000;

`ifdef ADPCM_MUL_SAT_EN
  localparam logic [15:0] E_SAT_POS = 16'h7FFF;
  localparam logic [15:0] E_SAT_NEG = 16'h8000;
  localparam logic        E_SAT_OVF = 1'b1;
`else
  localparam logic [15:0] E_SAT_POS = 16'h5F90;
  localparam logic [15:0] E_SAT_NEG = 16'hA070;
  localparam logic        E_SAT_OVF = 1'b0;
`endif

  adpcm_main_mul_pipe #(.ID(1), .NUM_STAGE(2), .din0_WIDTH(15), .din1_WIDTH(32), .dout_WIDTH(47),
    .SIGNED0(1), .SIGNED1(1), .SHIFT(0), .ROUND(1)) u_lat (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in), .din0(din0), .din1(din1),
    .dout(d_lat), .vld_out(v_lat), .ovf(o_lat));

  adpcm_main_mul_pipe #(.ID(2), .NUM_STAGE(2), .din0_WIDTH(15), .din1_WIDTH(32), .dout_WIDTH(32),
    .SIGNED0(1), .SIGNED1(1), .SHIFT(15), .ROUND(1)) u_rnd (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in), .din0(din0), .din1(din1),
    .dout(d_rnd), .vld_out(v_rnd), .ovf(o_rnd));

  adpcm_main_mul_pipe #(.ID(3), .NUM_STAGE(2), .din0_WIDTH(15), .din1_WIDTH(32), .dout_WIDTH(16),
    .SIGNED0(1), .SIGNED1(1), .SHIFT(0), .ROUND(0)) u_sat (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in), .din0(din0), .din1(din1),
    .dout(d_sat), .vld_out(v_sat), .ovf(o_sat));

  adpcm_main_mul_pipe #(.ID(4), .NUM_STAGE(4), .din0_WIDTH(15), .din1_WIDTH(32), .dout_WIDTH(32),
    .SIGNED0(1), .SIGNED1(1), .SHIFT(0), .ROUND(0)) u_rst (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in), .din0(din0), .din1(din1),
    .dout(d_rst), .vld_out(v_rst), .ovf(o_rst));

  adpcm_main_mul_pipe #(.ID(5), .NUM_STAGE(0), .din0_WIDTH(15), .din1_WIDTH(32), .dout_WIDTH(32),
    .SIGNED0(0), .SIGNED1(0), .SHIFT(0), .ROUND(0)) u_cmb (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in), .din0(din0), .din1(din1),
    .dout(d_cmb), .vld_out(v_cmb), .ovf(o_cmb));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic [14:0] a, input logic [31:0] b);
    ce     = c;
    vld_in = v;
    din0   = a;
    din1   = b;
  endtask

  // Stall timeline on u_lat: drive row i, take one edge, then check.
  int          st_ce   [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
  int          st_vin  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  int          st_k    [9] = '{1, 2, 3, 3, 3, 3, 4, 0, 0};
  int          st_evld [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int          st_ed   [9] = '{0, 1, 1, 1, 1, 2, 3, 4, 0};

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #2;
    check("rst_lat_vld", 64'(v_lat), 64'(1'b0));
    check("rst_lat_dout", 64'(d_lat), 64'd0);
    check("rst_sat_ovf", 64'(o_sat), 64'(1'b0));

    // Combinational instance ignores reset; 0x4000 is large unsigned, not negative.
    drive(1'b0, 1'b0, 15'h4000, 32'd2);
    #1;
    check("cmb_unsigned_msb", 64'(d_cmb), 64'h8000);

    // ce high during reset: reset wins.
    drive(1'b1, 1'b1, 15'd5, 32'd7);
    step();
    check("rst_wins_vld", 64'(v_lat), 64'(1'b0));
    step();
    check("rst_wins_dout", 64'(d_lat), 64'd0);
    #2 reset = 1'b1;
    drive(1'b0, 1'b1, 15'd5, 32'd7);
    step();
    step();
    check("post_rel_ce_low_vld", 64'(v_lat), 64'(1'b0));
    check("post_rel_ce_low_dout", 64'(d_lat), 64'd0);

    // Unsigned combinational path.
    drive(1'b1, 1'b1, 15'h7FFF, 32'd2);
    #1;
    check("cmb_dout", 64'(d_cmb), 64'hFFFE);
    check("cmb_vld_hi", 64'(v_cmb), 64'(1'b1));
    check("cmb_ovf", 64'(o_cmb), 64'(1'b0));
    vld_in = 1'b0;
    #1;
    check("cmb_vld_lo", 64'(v_cmb), 64'(1'b0));
    step();
    step();

    // Latency: single item, two edges, one-cycle valid pulse.
    drive(1'b1, 1'b1, -15'sd3, 32'd1000);
    step();
    drive(1'b1, 1'b0, '0, '0);
    check("lat_edge1_vld", 64'(v_lat), 64'(1'b0));
    step();
    check("lat_edge2_vld", 64'(v_lat), 64'(1'b1));
    check("lat_edge2_dout", 64'(d_lat), 64'(E_M3000));
    check("lat_edge2_ovf", 64'(o_lat), 64'(1'b0));
    step();
    check("lat_edge3_vld", 64'(v_lat), 64'(1'b0));

    // Rounding at SHIFT=15.
    drive(1'b1, 1'b1, 15'd1, 32'd16384);
    step();
    step();
    check("rnd_half_up", 64'(d_rnd), 64'd1);
    check("rnd_vld", 64'(v_rnd), 64'(1'b1));
    drive(1'b1, 1'b1, 15'd1, 32'd16383);
    step();
    step();
    check("rnd_below_half", 64'(d_rnd), 64'd0);
    drive(1'b1, 1'b1, -15'sd1, 32'd16385);
    step();
    step();
    check("rnd_negative", 64'(d_rnd), 64'hFFFF_FFFF);

    // Saturation / wrap into 16 bits.
    drive(1'b1, 1'b1, 15'd300, 32'd300);
    step();
    step();
    check("sat_pos_dout", 64'(d_sat), 64'(E_SAT_POS));
    check("sat_pos_ovf", 64'(o_sat), 64'(E_SAT_OVF));
    drive(1'b1, 1'b1, -15'sd300, 32'd300);
    step();
    step();
    check("sat_neg_dout", 64'(d_sat), 64'(E_SAT_NEG));
    check("sat_neg_ovf", 64'(o_sat), 64'(E_SAT_OVF));
    drive(1'b1, 1'b1, 15'd100, 32'd100);
    step();
    step();
    check("sat_inrange_dout", 64'(d_sat), 64'h2710);
    check("sat_inrange_ovf", 64'(o_sat), 64'(1'b0));
    vld_in = 1'b0;
    step();
    step();

    // Stall: ce low 3 cycles mid-stream; items 1..4 in order, held while stalled.
    for (int i = 0; i < 9; i++) begin
      drive(st_ce[i] != 0, st_vin[i] != 0, 15'd1, 32'(st_k[i]));
      step();
      check($sformatf("stall_vld_%0d", i), 64'(v_lat), 64'(st_evld[i] != 0));
      if (st_evld[i] != 0)
        check($sformatf("stall_dout_%0d", i), 64'(d_lat), 64'(st_ed[i]));
    end

    // Reset mid-flight on the 4-stage instance.
    for (int k = 5; k <= 8; k++) begin
      drive(1'b1, 1'b1, 15'd1, 32'(k));
      step();
    end
    drive(1'b1, 1'b0, '0, '0);
    check("rst4_pre_vld", 64'(v_rst), 64'(1'b1));
    check("rst4_pre_dout", 64'(d_rst), 64'd5);
    #2 reset = 1'b0;
    #1;
    check("rst4_async_vld", 64'(v_rst), 64'(1'b0));
    check("rst4_async_dout", 64'(d_rst), 64'd0);
    check("rst4_async_ovf", 64'(o_rst), 64'(1'b0));
    check("rst_async_lat_dout", 64'(d_lat), 64'd0);
    step();
    #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rst4_no_stale_vld_%0d", i), 64'(v_rst), 64'(1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
